// File: rtl/layer1_minimal.sv
// Layer-1 apical-gain block: weighted thalamic/feedback sum, slow SST+ low-pass
// filter, and a clamped multiplicative gain around 1.0 (signed Q14).
module layer1_minimal #(
    parameter int WIDTH = 18,
    parameter int FRAC  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] matrix_thalamic_input,
    input  logic signed [WIDTH-1:0] feedback_input_1,
    input  logic signed [WIDTH-1:0] feedback_input_2,
    output logic signed [WIDTH-1:0] apical_gain
);

    localparam int PW = 2 * WIDTH;   // full-precision product width
    localparam int SW = WIDTH + 3;   // weighted-sum width
    localparam int DW = WIDTH + 2;   // filter difference width
    localparam int GW = WIDTH + 1;   // gain pre-clamp width

    localparam logic signed [WIDTH-1:0] W_FB1 = WIDTH'(4915);
    localparam logic signed [WIDTH-1:0] W_FB2 = WIDTH'(3277);
    localparam logic signed [WIDTH-1:0] W_MAT = WIDTH'(2458);
    localparam logic signed [DW-1:0]    ALPHA = DW'(164);

    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1 << FRAC);
    localparam logic signed [SW-1:0]    SUM_MAX = SW'(1 << FRAC);
    localparam logic signed [SW-1:0]    SUM_MIN = -SUM_MAX;
    localparam logic signed [GW-1:0]    G_ONE   = GW'(1 << FRAC);
    localparam logic signed [GW-1:0]    G_MIN   = GW'(1 << (FRAC - 1));
    localparam logic signed [GW-1:0]    G_MAX   = GW'(3 << (FRAC - 1));

    logic signed [WIDTH-1:0] sst_state;

    logic signed [PW-1:0]    p_mat, p_fb1, p_fb2;
    logic signed [SW-1:0]    sum;
    logic signed [WIDTH-1:0] target;
    logic signed [DW-1:0]    diff;
    logic signed [2*DW-1:0]  dprod;
    logic signed [WIDTH-1:0] delta;
    logic signed [WIDTH-1:0] sst_next;
    logic signed [GW-1:0]    gain_sum;
    logic signed [WIDTH-1:0] gain_next;

    always_comb begin
        p_mat = PW'(matrix_thalamic_input) * PW'(W_MAT);
        p_fb1 = PW'(feedback_input_1) * PW'(W_FB1);
        p_fb2 = PW'(feedback_input_2) * PW'(W_FB2);
        sum   = SW'(p_mat >>> FRAC) + SW'(p_fb1 >>> FRAC) + SW'(p_fb2 >>> FRAC);

        if (sum > SUM_MAX)
            target = WIDTH'(SUM_MAX);
        else if (sum < SUM_MIN)
            target = WIDTH'(SUM_MIN);
        else
            target = WIDTH'(sum);

        // Flooring shift: rising steps stall short of target, falling steps land on it.
        diff     = DW'(target) - DW'(sst_state);
        dprod    = (2*DW)'(diff) * (2*DW)'(ALPHA);
        delta    = WIDTH'(dprod >>> FRAC);
        sst_next = sst_state + delta;

        // Clamp only the output; the filter state itself may run past +/-0.5.
        gain_sum = G_ONE + GW'(sst_next);
        if (gain_sum > G_MAX)
            gain_next = WIDTH'(G_MAX);
        else if (gain_sum < G_MIN)
            gain_next = WIDTH'(G_MIN);
        else
            gain_next = WIDTH'(gain_sum);
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous and wins over clk_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            sst_state   <= '0;
            apical_gain <= ONE;
        end else if (clk_en) begin
            sst_state   <= sst_next;
            apical_gain <= gain_next;
        end
    end

endmodule

// File: tb/tb_layer1_minimal.sv
// Self-checking bench for layer1_minimal: vector table of step phases with a
// per-tick scoreboard against a behavioural filter model, plus corner sequences.
module tb_layer1_minimal;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clk_en = 1'b0;
    logic signed [17:0] mat = '0;
    logic signed [17:0] fb1 = '0;
    logic signed [17:0] fb2 = '0;
    logic signed [17:0] apical_gain;

    layer1_minimal #(.WIDTH(18), .FRAC(14)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .clk_en                (clk_en),
        .matrix_thalamic_input (mat),
        .feedback_input_1      (fb1),
        .feedback_input_2      (fb2),
        .apical_gain           (apical_gain)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    longint m_sst = 0;
    longint exp_q[$];

    typedef struct {
        bit     do_reset;
        longint m;
        longint f1;
        longint f2;
        int     ticks;
        longint lo;
        longint hi;
        string  name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected in [%0d, %0d]", name, act, lo, hi);
        end
    endtask

    function automatic longint model_gain(input longint s);
        longint g;
        g = 16384 + s;
        if (g > 24576) g = 24576;
        if (g < 8192)  g = 8192;
        return g;
    endfunction

    function automatic void model_step(input longint m, input longint f1, input longint f2);
        longint t, d, dl;
        t = ((m * 2458) >>> 14) + ((f1 * 4915) >>> 14) + ((f2 * 3277) >>> 14);
        if (t > 16384)  t = 16384;
        if (t < -16384) t = -16384;
        d  = t - m_sst;
        dl = (d * 164) >>> 14;
        m_sst = m_sst + dl;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        clk_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_sst = 0;
        exp_q.delete();
        check("reset_gain", apical_gain, 16384);
    endtask

    // One enabled tick: expected gain is queued when stimulus is driven,
    // then popped and compared after the edge.
    task automatic tick(input string name, input longint m, input longint f1, input longint f2);
        longint e;
        mat = 18'(m);
        fb1 = 18'(f1);
        fb2 = 18'(f2);
        clk_en = 1'b1;
        model_step(m, f1, f2);
        exp_q.push_back(model_gain(m_sst));
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, apical_gain, e);
        end
    endtask

    initial begin
        longint held;

        vecs.push_back('{1, 0,      0,     0,      200, 16384, 16384, "idle_200"});
        vecs.push_back('{1, 0,      16384, 0,      5,   16384, 17999, "fb1_step_5"});
        vecs.push_back('{0, 0,      16384, 0,      95,  18001, 20999, "fb1_step_100"});
        vecs.push_back('{0, 0,      16384, 0,      400, 20501, 21999, "fb1_step_500"});
        vecs.push_back('{0, 0,      0,     0,      5,   18001, 24576, "fb1_off_5"});
        vecs.push_back('{0, 0,      0,     0,      500, 16184, 16584, "fb1_off_505"});
        vecs.push_back('{1, 32768,  32768, 32768,  600, 24576, 24576, "sat_high"});
        vecs.push_back('{1, -32768, -32768, -32768, 600, 8192, 8192,  "sat_low"});
        vecs.push_back('{1, 0,      0,     -16384, 300, 13000, 13600, "fb2_neg_300"});
        vecs.push_back('{1, 16384,  0,     0,      100, 17500, 18300, "mat_step_100"});

        do_reset();

        foreach (vecs[i]) begin
            if (vecs[i].do_reset) do_reset();
            for (int k = 0; k < vecs[i].ticks; k++)
                tick(vecs[i].name, vecs[i].m, vecs[i].f1, vecs[i].f2);
            check_range({vecs[i].name, "_range"}, apical_gain, vecs[i].lo, vecs[i].hi);
        end

        // Reset mid-rise: history is discarded on the very next edge.
        do_reset();
        for (int k = 0; k < 50; k++) tick("rise_pre_reset", 0, 16384, 0);
        check_range("rise_moved", apical_gain, 16500, 19000);
        rst = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clk_en = 1'b0;
        m_sst = 0;
        exp_q.delete();
        check("mid_rise_reset", apical_gain, 16384);
        for (int k = 0; k < 10; k++) tick("post_reset_rise", 0, 16384, 0);

        // Enable held low: gain must hold for 100 cycles while inputs wander.
        held = model_gain(m_sst);
        for (int k = 0; k < 100; k++) begin
            mat = 18'($signed($urandom_range(65535)) - 32768);
            fb1 = 18'($signed($urandom_range(65535)) - 32768);
            fb2 = 18'($signed($urandom_range(65535)) - 32768);
            clk_en = 1'b0;
            @(posedge clk);
            #1;
            if (k % 10 == 9) check("enable_low_hold", apical_gain, held);
        end
        tick("resume_after_hold", 0, 16384, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
